// File: rtl/braille_mode_pkg.sv
// Shared types and helpers for the trainer mode controller.
package braille_mode_pkg;

    typedef enum logic [1:0] {
        S_NONE,
        S_ACTIVE,
        S_DRAIN
    } state_t;

    localparam int MODE_NONE   = 0;
    localparam int MODE_LEARN  = 1;
    localparam int MODE_ASSESS = 2;
    localparam int MODE_GAME   = 3;

    localparam int MAX_MODES = 16;
    localparam int MAX_SEL_W = 5;

    // Code 0 maps to an all-zero vector; callers size-cast down to NUM_MODES.
    function automatic logic [MAX_MODES-1:0] code_to_onehot(input logic [MAX_SEL_W-1:0] code);
        logic [MAX_MODES-1:0] oh;
        oh = '0;
        if (code != '0) begin
            oh = MAX_MODES'(1) << (code - 1'b1);
        end
        return oh;
    endfunction

endpackage

// File: rtl/mode_idle_timer.sv
// Idle timer for the active mode: counts idle cycles, flags the last one.
module mode_idle_timer #(
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int CNT_W          = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic run,
    output logic expire
);

    generate
        if (TIMEOUT_CYCLES == 0) begin : g_off
            assign expire = 1'b0;
        end else begin : g_on
            localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);
            logic [CNT_W-1:0] idle_cnt;

            always_ff @(posedge clk) begin
                if (!rst) begin
                    idle_cnt <= '0;
                end else if (clr) begin
                    idle_cnt <= '0;
                end else if (run) begin
                    idle_cnt <= idle_cnt + 1'b1;
                end
            end

            assign expire = run && (idle_cnt == LAST);
        end
    endgenerate

endmodule

// File: rtl/mode_controller.sv
// Password-gated one-hot mode selection with break-before-make switching,
// explicit "no mode" command, invalid-code error and inactivity timeout.
import braille_mode_pkg::*;

//  state    | meaning
//  S_NONE   | no mode driven
//  S_ACTIVE | mode_oh drives the current mode, idle timer running
//  S_DRAIN  | outputs dropped, waiting for mode_busy==0 to raise pending
module mode_controller #(
    parameter int NUM_MODES      = 3,
    parameter int SEL_W          = $clog2(NUM_MODES + 1),
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int CNT_W          = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 mode_selector,
    input  logic                 pass_load,
    input  logic [SEL_W-1:0]     mode_ip,
    input  logic                 activity,
    input  logic                 mode_busy,
    output logic [NUM_MODES-1:0] mode_oh,
    output logic [SEL_W-1:0]     mode_code,
    output logic                 mode_valid,
    output logic                 switch_done,
    output logic                 mode_err,
    output logic                 timeout
);

    state_t               state, state_nxt;
    logic [SEL_W-1:0]     pending, pending_nxt;
    logic [SEL_W-1:0]     code_nxt, drain_tgt;
    logic [NUM_MODES-1:0] oh_nxt;
    logic                 sd_nxt, err_nxt, to_nxt;
    logic                 load, code_z, code_x, code_v;
    logic                 timer_clr, timer_run, expire;

    assign load   = mode_selector & pass_load;
    assign code_z = (mode_ip == SEL_W'(MODE_NONE));
    assign code_x = (mode_ip > SEL_W'(NUM_MODES));
    assign code_v = !code_z && !code_x;

    // An invalid-code load freezes the timer along with everything else.
    assign timer_run = (state == S_ACTIVE) && !load && !activity;
    assign timer_clr = (state != S_ACTIVE) || (load ? !code_x : activity);

    mode_idle_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .CNT_W          (CNT_W)
    ) u_idle_timer (
        .clk    (clk),
        .rst    (rst),
        .clr    (timer_clr),
        .run    (timer_run),
        .expire (expire)
    );

    always_comb begin
        state_nxt   = state;
        pending_nxt = pending;
        oh_nxt      = mode_oh;
        code_nxt    = mode_code;
        sd_nxt      = 1'b0;
        err_nxt     = 1'b0;
        to_nxt      = 1'b0;
        drain_tgt   = (load && code_v) ? mode_ip : pending;

        if (load && code_x) begin
            err_nxt = 1'b1;
        end else begin
            case (state)
                S_NONE: begin
                    if (load && code_v) begin
                        oh_nxt    = NUM_MODES'(code_to_onehot(MAX_SEL_W'(mode_ip)));
                        code_nxt  = mode_ip;
                        sd_nxt    = 1'b1;
                        state_nxt = S_ACTIVE;
                    end
                end
                S_ACTIVE: begin
                    if (load && code_v) begin
                        if (mode_ip != mode_code) begin
                            oh_nxt      = '0;
                            code_nxt    = '0;
                            pending_nxt = mode_ip;
                            state_nxt   = S_DRAIN;
                        end
                    end else if (load && code_z) begin
                        oh_nxt    = '0;
                        code_nxt  = '0;
                        state_nxt = S_NONE;
                    end else if (expire) begin
                        oh_nxt    = '0;
                        code_nxt  = '0;
                        to_nxt    = 1'b1;
                        state_nxt = S_NONE;
                    end
                end
                S_DRAIN: begin
                    if (load && code_z) begin
                        pending_nxt = '0;
                        state_nxt   = S_NONE;
                    end else if (!mode_busy) begin
                        oh_nxt      = NUM_MODES'(code_to_onehot(MAX_SEL_W'(drain_tgt)));
                        code_nxt    = drain_tgt;
                        sd_nxt      = 1'b1;
                        pending_nxt = '0;
                        state_nxt   = S_ACTIVE;
                    end else begin
                        pending_nxt = drain_tgt;
                    end
                end
                default: begin
                    oh_nxt      = '0;
                    code_nxt    = '0;
                    pending_nxt = '0;
                    state_nxt   = S_NONE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= S_NONE;
            pending     <= '0;
            mode_oh     <= '0;
            mode_code   <= '0;
            mode_valid  <= 1'b0;
            switch_done <= 1'b0;
            mode_err    <= 1'b0;
            timeout     <= 1'b0;
        end else begin
            state       <= state_nxt;
            pending     <= pending_nxt;
            mode_oh     <= oh_nxt;
            mode_code   <= code_nxt;
            mode_valid  <= |oh_nxt;
            switch_done <= sd_nxt;
            mode_err    <= err_nxt;
            timeout     <= to_nxt;
        end
    end

endmodule

// File: tb/tb_mode_controller.sv
// Directed and randomized checks of mode_controller against an abstract model.
module tb_mode_controller;

    localparam int NM = 3;
    localparam int TO = 8;

    logic       clk = 1'b0;
    logic       rst, mode_selector, pass_load, activity, mode_busy;
    logic [2:0] mode_ip;
    logic [2:0] mode_oh;
    logic [2:0] mode_code;
    logic       mode_valid, switch_done, mode_err, timeout;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: cur = active mode (0 none), tgt = mode awaited while draining.
    int m_cur = 0, m_tgt = 0, m_idle = 0;
    bit m_sd = 0, m_err = 0, m_to = 0;

    always #5 clk = ~clk;

    mode_controller #(
        .NUM_MODES      (NM),
        .SEL_W          (3),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .mode_selector (mode_selector),
        .pass_load     (pass_load),
        .mode_ip       (mode_ip),
        .activity      (activity),
        .mode_busy     (mode_busy),
        .mode_oh       (mode_oh),
        .mode_code     (mode_code),
        .mode_valid    (mode_valid),
        .switch_done   (switch_done),
        .mode_err      (mode_err),
        .timeout       (timeout)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_update(input bit r, input bit ld, input int code, input bit act,
                                input bit busy);
        m_sd  = 0;
        m_err = 0;
        m_to  = 0;
        if (!r) begin
            m_cur  = 0;
            m_tgt  = 0;
            m_idle = 0;
        end else if (ld && code > NM) begin
            m_err = 1;
        end else if (m_tgt != 0) begin
            if (ld && code == 0) begin
                m_tgt = 0;
            end else begin
                if (ld) m_tgt = code;
                if (!busy) begin
                    m_cur  = m_tgt;
                    m_tgt  = 0;
                    m_sd   = 1;
                    m_idle = 0;
                end
            end
        end else if (m_cur == 0) begin
            if (ld && code != 0) begin
                m_cur  = code;
                m_sd   = 1;
                m_idle = 0;
            end
        end else begin
            if (ld && code == m_cur) begin
                m_idle = 0;
            end else if (ld && code != 0) begin
                m_tgt = code;
                m_cur = 0;
            end else if (ld) begin
                m_cur = 0;
            end else if (act) begin
                m_idle = 0;
            end else begin
                m_idle++;
                if (m_idle == TO) begin
                    m_cur  = 0;
                    m_idle = 0;
                    m_to   = 1;
                end
            end
        end
    endtask

    task automatic check_outputs();
        int exp_oh;
        exp_oh = (m_cur == 0) ? 0 : (1 << (m_cur - 1));
        chk("mode_oh", mode_oh, exp_oh);
        chk("mode_code", mode_code, m_cur);
        chk("mode_valid", mode_valid, (m_cur != 0));
        chk("switch_done", switch_done, m_sd);
        chk("mode_err", mode_err, m_err);
        chk("timeout", timeout, m_to);
        chk("onehot_inv", ($countones(mode_oh) <= 1), 1);
    endtask

    task automatic step(input bit r, input bit sel, input bit pl, input int code,
                        input bit act, input bit busy);
        rst           = r;
        mode_selector = sel;
        pass_load     = pl;
        mode_ip       = 3'(code);
        activity      = act;
        mode_busy     = busy;
        @(posedge clk);
        model_update(r, sel && pl, code, act, busy);
        #1;
        check_outputs();
    endtask

    initial begin
        bit busy_r;
        int code;
        bit sel, pl;

        // reset
        step(0, 0, 0, 0, 0, 0);
        step(0, 1, 1, 2, 0, 0);
        // first mode, half-handshakes ignored
        step(1, 1, 1, 1, 0, 0);
        step(1, 1, 0, 3, 0, 0);
        step(1, 0, 1, 3, 1, 0);
        // switch 1 -> 3 with busy held four cycles
        step(1, 1, 1, 3, 0, 1);
        for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 0, 1);
        step(1, 0, 0, 0, 0, 0);
        // drain toward 2, overwritten by 3, aborted by 0
        step(1, 1, 1, 2, 0, 1);
        step(1, 1, 1, 3, 0, 1);
        step(1, 1, 1, 0, 0, 1);
        step(1, 0, 0, 0, 0, 0);
        // enter 2, then out-of-range code
        step(1, 1, 1, 2, 0, 0);
        step(1, 1, 1, 5, 0, 0);
        // inactivity drop after exactly TO cycles
        for (int i = 0; i < TO + 3; i++) step(1, 0, 0, 0, 0, 0);
        // activity every 5 cycles keeps mode 2 alive
        step(1, 1, 1, 2, 0, 0);
        for (int i = 0; i < 30; i++) step(1, 0, 0, 0, (i % 5 == 4), 0);
        // reset during drain, then busy released without a load
        step(1, 1, 1, 1, 0, 1);
        step(0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 0);

        busy_r = 0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 3) == 0) busy_r = ~busy_r;
            code = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 7))
                                               : int'($urandom_range(1, 3));
            if ($urandom_range(0, 5) == 0) begin
                sel = 1;
                pl  = 1;
            end else begin
                sel = ($urandom_range(0, 3) == 0);
                pl  = 0;
                if (!sel) pl = ($urandom_range(0, 3) == 0);
            end
            step(($urandom_range(0, 299) != 0), sel, pl, code,
                 ($urandom_range(0, 6) == 0), busy_r);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mode_controller.md
Name: mode_controller

Overview:
- Parametrised successor to the trainer's mode selection: password-gated selection among NUM_MODES exclusive trainer modes (default learn/assess/game), driven as a one-hot vector.
- New behaviour:
  - break-before-make switching with a downstream busy handshake
  - explicit "no mode" command
  - invalid-code error pulse
  - inactivity timeout that drops the active mode
- Sits between the password/keypad front end and the mode datapaths (learn, assess, game).

Parameters:
- NUM_MODES, 3: number of selectable modes; codes 1..NUM_MODES are valid.
- SEL_W, $clog2(NUM_MODES+1): width of the mode code; default 2.
- TIMEOUT_CYCLES, 1000: idle cycles in ACTIVE before auto-drop; 0 disables the timeout.
- CNT_W, $clog2(TIMEOUT_CYCLES+1): idle counter width.

Ports:
- clk  in  1  system clock; single clock domain.
- rst  in  1  synchronous reset, active-low (rst==0 resets on the rising edge of clk).
- mode_selector  in  1  mode-entry enable from the front end.
- pass_load  in  1  password accepted; a load is valid only when mode_selector==1 and pass_load==1 in the same cycle.
- mode_ip  in  SEL_W  requested mode code; 0 = none.
- activity  in  1  user-activity strobe from the active datapath; reloads the idle timer.
- mode_busy  in  1  current datapath still busy; a switch waits for this to drop.
- mode_oh  out  NUM_MODES  one-hot active mode; bit k-1 = code k (bit0 learn, bit1 assess, bit2 game).
- mode_code  out  SEL_W  binary code of the active mode; 0 when none or draining.
- mode_valid  out  1  a mode is active (== |mode_oh).
- switch_done  out  1  one-cycle pulse on the cycle a new mode first appears on mode_oh.
- mode_err  out  1  one-cycle pulse, cycle after a load with code > NUM_MODES.
- timeout  out  1  one-cycle pulse, cycle the mode is dropped by inactivity.

Behaviour:
- All outputs registered. Reset values:
  - state=NONE, mode_oh=0, mode_code=0, mode_valid=0, switch_done=0, mode_err=0, timeout=0
  - pending=0, idle_cnt=0
- Load classes: V = valid code 1..NUM_MODES, Z = code 0, X = code > NUM_MODES.
- X in any state: mode_err=1 next cycle; state, outputs and timer unchanged.
- State NONE:
  - V(k): next cycle mode_oh[k-1]=1, mode_code=k, switch_done=1, enter ACTIVE, idle_cnt=0. Latency 1 cycle.
  - Z: no effect.
- State ACTIVE:
  - V(k==current): stay; idle_cnt reloads to 0; no switch_done.
  - V(k!=current): next cycle mode_oh=0, mode_code=0, pending=k, enter DRAIN.
  - Z: next cycle all mode outputs 0, enter NONE; no pulse.
  - Otherwise, activity==1: idle_cnt=0; else idle_cnt+1.
  - If idle_cnt==TIMEOUT_CYCLES-1 and there is no activity and no load: next cycle enter NONE, outputs cleared, timeout=1. With no activity at all, the mode is held exactly TIMEOUT_CYCLES cycles.
- State DRAIN (minimum 1 cycle; mode outputs 0; timer frozen at 0):
  - mode_busy==0 sampled: next cycle mode_oh[pending-1]=1, mode_code=pending, switch_done=1, enter ACTIVE.
  - V(k): pending=k (last request wins); the drain exit condition still applies the same cycle with the new pending.
  - Z: abort to NONE; pending cleared.
  - No drain time limit; the downstream datapath must release mode_busy.
- Priority within a cycle: rst > load > timeout expiry > activity. A load coinciding with expiry suppresses the timeout pulse.
- mode_selector==1 with pass_load==0, or pass_load==1 with mode_selector==0: ignored (hold).
- Reset mid-DRAIN or mid-ACTIVE: immediate return to reset values on that edge; pending discarded.
- Invariant: mode_oh is zero or one-hot at all times; never two bits set, including across switches.

Decomposition:
- Package braille_mode_pkg:
  - state enum {S_NONE, S_ACTIVE, S_DRAIN}
  - code constants MODE_NONE=0, MODE_LEARN=1, MODE_ASSESS=2, MODE_GAME=3
  - function code_to_onehot(code)
- Sub-module mode_idle_timer (params TIMEOUT_CYCLES, CNT_W):
  - ports clk, rst, clr, run, expire
  - expire combinational on idle_cnt==TIMEOUT_CYCLES-1 && run
  - tied off when TIMEOUT_CYCLES==0.
- FSM and output registers stay in mode_controller.

Test Plan:
- Reset, then load code 1 (mode_selector=1, pass_load=1) -> next cycle mode_oh=3'b001, mode_code=1, switch_done=1 for exactly 1 cycle.
- In ACTIVE(1), load code 3 with mode_busy=1 for 4 cycles -> mode_oh=0 from the next cycle until busy drops, then mode_oh=3'b100, switch_done=1; mode_oh is never 3'b101.
- In DRAIN toward 2, load code 3 then code 0 -> pending overwritten to 3; the code-0 load returns to NONE, and switch_done never fires.
- Load code 2 with mode_ip width widened by override (NUM_MODES=3, SEL_W=3, code 5) -> mode_err pulse; mode_oh unchanged.
- TIMEOUT_CYCLES=8, ACTIVE(2), no activity -> mode_oh=3'b010 for exactly 8 cycles, then 0 with timeout=1; with activity every 5 cycles, never times out.
- rst=0 asserted during DRAIN with mode_busy=1 -> all outputs 0 on the next edge; after release, mode_busy=0 with no load produces no mode.
